// File: rtl/issue_queue_compact.sv
// Age-ordered collapsing issue queue: oldest entry lives at index 0, up to ISS_W
// oldest ready uops are granted to ready channels each cycle, survivors slide down.
module issue_queue_compact #(
  parameter int DEPTH  = 8,
  parameter int ENQ_W  = 2,
  parameter int ISS_W  = 2,
  parameter int WAKE_N = 4,
  parameter int PREG_W = 6,
  parameter int PL_W   = 64,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [ENQ_W-1:0]          enq_valid,
  input  logic [ENQ_W*PL_W-1:0]     enq_payload,
  input  logic [ENQ_W*PREG_W-1:0]   enq_prs1,
  input  logic [ENQ_W*PREG_W-1:0]   enq_prs2,
  input  logic [ENQ_W-1:0]          enq_rdy1,
  input  logic [ENQ_W-1:0]          enq_rdy2,
  output logic                      enq_ready,
  input  logic [WAKE_N-1:0]         wake_valid,
  input  logic [WAKE_N*PREG_W-1:0]  wake_preg,
  input  logic [ISS_W-1:0]          iss_ready,
  output logic [ISS_W-1:0]          iss_valid,
  output logic [ISS_W*PL_W-1:0]     iss_payload,
  output logic [CNT_W-1:0]          count
);

  // Wide enough to hold any rank, position or count without wrap.
  localparam int IW = $clog2(DEPTH + ENQ_W + ISS_W + 1) + 1;
  typedef logic [IW-1:0] idx_t;

  logic [PL_W-1:0]   payload_reg [DEPTH];
  logic [PL_W-1:0]   payload_next [DEPTH];
  logic [PREG_W-1:0] prs1_reg [DEPTH];
  logic [PREG_W-1:0] prs1_next [DEPTH];
  logic [PREG_W-1:0] prs2_reg [DEPTH];
  logic [PREG_W-1:0] prs2_next [DEPTH];
  logic [DEPTH-1:0]  r1_reg, r1_next, r2_reg, r2_next;
  logic [CNT_W-1:0]  count_reg, count_next;

  logic [DEPTH-1:0]  valid_e, eligible, grant, surv_r1, surv_r2;
  logic [PL_W-1:0]   lane_pl [ENQ_W];
  logic [PREG_W-1:0] lane_prs1 [ENQ_W];
  logic [PREG_W-1:0] lane_prs2 [ENQ_W];
  logic [ENQ_W-1:0]  lane_r1, lane_r2;
  idx_t              e_rank [DEPTH];
  idx_t              s_pos [DEPTH];
  idx_t              c_rank [ISS_W];
  idx_t              l_pos [ENQ_W];
  idx_t              n_elig, n_rdy, n_grant, count_ext;
  logic              enq_fire;

  // Register 0 is hard-wired ready; otherwise any matching wakeup port readies it.
  function automatic logic woken(input logic [PREG_W-1:0]        preg,
                                 input logic [WAKE_N-1:0]        wv,
                                 input logic [WAKE_N*PREG_W-1:0] wp);
    logic hit;
    hit = (preg == '0);
    for (int p = 0; p < WAKE_N; p++) begin
      if (wv[p] && (wp[p*PREG_W +: PREG_W] == preg)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign count_ext = idx_t'(count_reg);
  assign count     = count_reg;
  assign enq_ready = (idx_t'(DEPTH) - count_ext) >= idx_t'(ENQ_W);
  assign enq_fire  = enq_ready && !flush;

  generate
    for (genvar gi = 0; gi < ENQ_W; gi++) begin : g_lane
      assign lane_pl[gi]   = enq_payload[gi*PL_W +: PL_W];
      assign lane_prs1[gi] = enq_prs1[gi*PREG_W +: PREG_W];
      assign lane_prs2[gi] = enq_prs2[gi*PREG_W +: PREG_W];
      assign lane_r1[gi]   = enq_rdy1[gi] | woken(lane_prs1[gi], wake_valid, wake_preg);
      assign lane_r2[gi]   = enq_rdy2[gi] | woken(lane_prs2[gi], wake_valid, wake_preg);
    end
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign valid_e[gi]  = idx_t'(gi) < count_ext;
      assign eligible[gi] = valid_e[gi] && r1_reg[gi] && r2_reg[gi];
      assign surv_r1[gi]  = r1_reg[gi] | woken(prs1_reg[gi], wake_valid, wake_preg);
      assign surv_r2[gi]  = r2_reg[gi] | woken(prs2_reg[gi], wake_valid, wake_preg);
    end
  endgenerate

  // Pair the j-th oldest eligible entry with the j-th ready channel.
  always_comb begin : select_c
    idx_t acc_e, acc_c;
    acc_e = '0;
    for (int i = 0; i < DEPTH; i++) begin
      e_rank[i] = acc_e;
      acc_e     = acc_e + idx_t'(eligible[i]);
    end
    n_elig = acc_e;
    acc_c = '0;
    for (int k = 0; k < ISS_W; k++) begin
      c_rank[k] = acc_c;
      acc_c     = acc_c + idx_t'(iss_ready[k]);
    end
    n_rdy   = acc_c;
    n_grant = (n_elig < n_rdy) ? n_elig : n_rdy;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = eligible[i] && (e_rank[i] < n_grant);
    end
  end

  always_comb begin : issue_c
    iss_valid   = '0;
    iss_payload = '0;
    for (int k = 0; k < ISS_W; k++) begin
      if (iss_ready[k] && (c_rank[k] < n_elig)) begin
        iss_valid[k] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          if (eligible[i] && (e_rank[i] == c_rank[k])) begin
            iss_payload[k*PL_W +: PL_W] = payload_reg[i];
          end
        end
      end
    end
  end

  // Survivors collapse to 0..count-m-1; new lanes are packed right after them.
  always_comb begin : compact_c
    idx_t acc, base;
    acc = '0;
    for (int i = 0; i < DEPTH; i++) begin
      s_pos[i] = acc;
      acc      = acc + idx_t'(valid_e[i] && !grant[i]);
    end
    base = acc;
    for (int l = 0; l < ENQ_W; l++) begin
      l_pos[l] = acc;
      acc      = acc + idx_t'(enq_valid[l]);
    end
    r1_next = '0;
    r2_next = '0;
    for (int j = 0; j < DEPTH; j++) begin
      payload_next[j] = '0;
      prs1_next[j]    = '0;
      prs2_next[j]    = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_e[i] && !grant[i] && (s_pos[i] == idx_t'(j))) begin
          payload_next[j] = payload_reg[i];
          prs1_next[j]    = prs1_reg[i];
          prs2_next[j]    = prs2_reg[i];
          r1_next[j]      = surv_r1[i];
          r2_next[j]      = surv_r2[i];
        end
      end
      for (int l = 0; l < ENQ_W; l++) begin
        if (enq_fire && enq_valid[l] && (l_pos[l] == idx_t'(j))) begin
          payload_next[j] = lane_pl[l];
          prs1_next[j]    = lane_prs1[l];
          prs2_next[j]    = lane_prs2[l];
          r1_next[j]      = lane_r1[l];
          r2_next[j]      = lane_r2[l];
        end
      end
    end
    if (flush) begin
      count_next = '0;
      r1_next    = '0;
      r2_next    = '0;
    end else if (enq_fire) begin
      count_next = CNT_W'(acc);
    end else begin
      count_next = CNT_W'(base);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      r1_reg    <= '0;
      r2_reg    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        payload_reg[i] <= '0;
        prs1_reg[i]    <= '0;
        prs2_reg[i]    <= '0;
      end
    end else begin
      count_reg <= count_next;
      r1_reg    <= r1_next;
      r2_reg    <= r2_next;
      for (int i = 0; i < DEPTH; i++) begin
        payload_reg[i] <= payload_next[i];
        prs1_reg[i]    <= prs1_next[i];
        prs2_reg[i]    <= prs2_next[i];
      end
    end
  end

endmodule

// File: tb/tb_issue_queue_compact.sv
// Bench for issue_queue_compact: scenario tasks with inline checks plus an issue
// scoreboard that pairs each granted uop with its expected channel and payload.
module tb_issue_queue_compact;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic [1:0]    enq_valid, enq_rdy1, enq_rdy2;
  logic [127:0]  enq_payload;
  logic [11:0]   enq_prs1, enq_prs2;
  logic          enq_ready;
  logic [3:0]    wake_valid;
  logic [23:0]   wake_preg;
  logic [1:0]    iss_ready, iss_valid;
  logic [127:0]  iss_payload;
  logic [3:0]    count;

  typedef struct {
    int          ch;
    logic [63:0] pl;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fails  = 0;

  issue_queue_compact dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_payload(enq_payload),
    .enq_prs1(enq_prs1), .enq_prs2(enq_prs2),
    .enq_rdy1(enq_rdy1), .enq_rdy2(enq_rdy2), .enq_ready(enq_ready),
    .wake_valid(wake_valid), .wake_preg(wake_preg),
    .iss_ready(iss_ready), .iss_valid(iss_valid), .iss_payload(iss_payload),
    .count(count)
  );

  always #5 clk = ~clk;

  // Every issued uop must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (iss_valid[k]) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fails++;
            $display("FAIL sb_unexpected ch=%0d got payload %h, required no issue", k, iss_payload[k*64 +: 64]);
          end else begin
            mon_e = sb.pop_front();
            if (mon_e.ch != k || iss_payload[k*64 +: 64] !== mon_e.pl) begin
              n_fails++;
              $display("FAIL sb_issue got ch=%0d payload %h, required ch=%0d payload %h",
                       k, iss_payload[k*64 +: 64], mon_e.ch, mon_e.pl);
            end else begin
              $display("issue ch=%0d payload %h", k, mon_e.pl);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lanes();
    enq_valid = '0; enq_payload = '0; enq_prs1 = '0; enq_prs2 = '0;
    enq_rdy1 = '0; enq_rdy2 = '0;
  endtask

  task automatic set_lane(input int l, input logic [63:0] pl, input logic [5:0] p1,
                          input logic [5:0] p2, input logic r1, input logic r2);
    enq_valid[l] = 1'b1;
    enq_payload[l*64 +: 64] = pl;
    enq_prs1[l*6 +: 6] = p1;
    enq_prs2[l*6 +: 6] = p2;
    enq_rdy1[l] = r1;
    enq_rdy2[l] = r2;
  endtask

  task automatic push(input int ch, input logic [63:0] pl);
    exp_t e;
    e.ch = ch;
    e.pl = pl;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    iss_ready = 2'b11;
    repeat (2) @(negedge clk);
    n_checks++; if (count !== 4'd0) begin n_fails++; $display("FAIL reset_count got %0d required 0", count); end
    n_checks++; if (iss_valid !== 2'b00) begin n_fails++; $display("FAIL reset_iss_valid got %b required 00", iss_valid); end
    n_checks++; if (iss_payload !== 128'd0) begin n_fails++; $display("FAIL reset_iss_payload got %h required 0", iss_payload); end
    n_checks++; if (enq_ready !== 1'b1) begin n_fails++; $display("FAIL reset_enq_ready got %b required 1", enq_ready); end
    $display("reset checked");
    rst = 1'b0;
    iss_ready = 2'b00;
  endtask

  task automatic test_wakeup();
    iss_ready = 2'b11;
    tick(); set_lane(0, 64'hA1, 6'd3, 6'd0, 1'b0, 1'b0); set_lane(1, 64'hA2, 6'd3, 6'd0, 1'b0, 1'b0);
    tick(); clear_lanes();
    @(negedge clk);
    n_checks++; if (iss_valid !== 2'b00) begin n_fails++; $display("FAIL wake_idle_valid got %b required 00", iss_valid); end
    n_checks++; if (count !== 4'd2) begin n_fails++; $display("FAIL wake_count got %0d required 2", count); end
    tick(); wake_valid = 4'b0001; wake_preg = '0; wake_preg[5:0] = 6'd3;
    push(0, 64'hA1); push(1, 64'hA2);
    @(negedge clk);
    n_checks++; if (iss_valid !== 2'b00) begin n_fails++; $display("FAIL wake_no_bypass got %b required 00", iss_valid); end
    tick(); wake_valid = '0; wake_preg = '0;
    @(negedge clk);
    n_checks++; if (iss_valid !== 2'b11) begin n_fails++; $display("FAIL wake_issue_valid got %b required 11", iss_valid); end
    tick();
    @(negedge clk);
    n_checks++; if (count !== 4'd0) begin n_fails++; $display("FAIL wake_drained got %0d required 0", count); end
    $display("wakeup scenario done");
    iss_ready = 2'b00;
  endtask

  task automatic test_fill();
    iss_ready = 2'b00;
    for (int c = 0; c < 4; c++) begin
      tick(); clear_lanes();
      set_lane(0, 64'hB0 + 64'(2*c), 6'd0, 6'd0, 1'b1, 1'b1);
      set_lane(1, 64'hB1 + 64'(2*c), 6'd0, 6'd0, 1'b1, 1'b1);
      @(negedge clk);
      n_checks++; if (count !== 4'(2*c)) begin n_fails++; $display("FAIL fill_count got %0d required %0d", count, 2*c); end
      n_checks++; if (enq_ready !== 1'b1) begin n_fails++; $display("FAIL fill_enq_ready got %b required 1", enq_ready); end
    end
    tick(); clear_lanes();
    @(negedge clk);
    n_checks++; if (count !== 4'd8) begin n_fails++; $display("FAIL full_count got %0d required 8", count); end
    n_checks++; if (enq_ready !== 1'b0) begin n_fails++; $display("FAIL full_enq_ready got %b required 0", enq_ready); end
    tick(); iss_ready = 2'b01; push(0, 64'hB0);
    @(negedge clk);
    n_checks++; if (iss_valid !== 2'b01) begin n_fails++; $display("FAIL full_issue_valid got %b required 01", iss_valid); end
    n_checks++; if (enq_ready !== 1'b0) begin n_fails++; $display("FAIL full_issue_enq_ready got %b required 0", enq_ready); end
    tick(); iss_ready = 2'b00;
    set_lane(0, 64'hC0, 6'd0, 6'd0, 1'b1, 1'b1); set_lane(1, 64'hC1, 6'd0, 6'd0, 1'b1, 1'b1);
    @(negedge clk);
    n_checks++; if (count !== 4'd7) begin n_fails++; $display("FAIL seven_count got %0d required 7", count); end
    n_checks++; if (enq_ready !== 1'b0) begin n_fails++; $display("FAIL seven_enq_ready got %b required 0", enq_ready); end
    tick(); clear_lanes();
    @(negedge clk);
    n_checks++; if (count !== 4'd7) begin n_fails++; $display("FAIL drop_count got %0d required 7", count); end
    tick(); iss_ready = 2'b11;
    for (int i = 1; i < 8; i++) push((i - 1) % 2, 64'hB0 + 64'(i));
    repeat (4) tick();
    iss_ready = 2'b00;
    @(negedge clk);
    n_checks++; if (count !== 4'd0) begin n_fails++; $display("FAIL fill_drained got %0d required 0", count); end
    $display("fill scenario done");
  endtask

  task automatic test_select();
    iss_ready = 2'b00;
    tick(); clear_lanes(); set_lane(0, 64'h50, 6'd7, 6'd0, 1'b0, 1'b0); set_lane(1, 64'h51, 6'd0, 6'd0, 1'b1, 1'b1);
    tick(); clear_lanes(); set_lane(0, 64'h52, 6'd7, 6'd0, 1'b0, 1'b0); set_lane(1, 64'h53, 6'd7, 6'd0, 1'b0, 1'b0);
    tick(); clear_lanes(); set_lane(0, 64'h54, 6'd7, 6'd0, 1'b0, 1'b0); set_lane(1, 64'h55, 6'd0, 6'd0, 1'b1, 1'b1);
    tick(); clear_lanes(); iss_ready = 2'b10; push(1, 64'h51);
    @(negedge clk);
    n_checks++; if (iss_valid !== 2'b10) begin n_fails++; $display("FAIL sel_valid got %b required 10", iss_valid); end
    n_checks++; if (iss_payload[63:0] !== 64'd0) begin n_fails++; $display("FAIL sel_idle_payload got %h required 0", iss_payload[63:0]); end
    n_checks++; if (count !== 4'd6) begin n_fails++; $display("FAIL sel_count got %0d required 6", count); end
    tick(); iss_ready = 2'b01; push(0, 64'h55);
    @(negedge clk);
    n_checks++; if (iss_valid !== 2'b01) begin n_fails++; $display("FAIL sel_second_valid got %b required 01", iss_valid); end
    tick(); iss_ready = 2'b00; wake_valid = 4'b0100; wake_preg = '0; wake_preg[12 +: 6] = 6'd7;
    @(negedge clk);
    n_checks++; if (count !== 4'd4) begin n_fails++; $display("FAIL sel_left_count got %0d required 4", count); end
    tick(); wake_valid = '0; wake_preg = '0; iss_ready = 2'b11;
    push(0, 64'h50); push(1, 64'h52); push(0, 64'h53); push(1, 64'h54);
    repeat (2) tick();
    iss_ready = 2'b00;
    @(negedge clk);
    n_checks++; if (count !== 4'd0) begin n_fails++; $display("FAIL sel_drained got %0d required 0", count); end
    $display("select scenario done");
  endtask

  task automatic test_issue_enq();
    iss_ready = 2'b00;
    tick(); clear_lanes(); set_lane(0, 64'hE0, 6'd0, 6'd0, 1'b1, 1'b1); set_lane(1, 64'hE1, 6'd8, 6'd0, 1'b0, 1'b0);
    tick(); clear_lanes(); set_lane(0, 64'hE2, 6'd0, 6'd0, 1'b1, 1'b1); set_lane(1, 64'hE3, 6'd8, 6'd0, 1'b0, 1'b0);
    tick(); clear_lanes();
    set_lane(0, 64'hDEAD, 6'd0, 6'd0, 1'b1, 1'b1); enq_valid[0] = 1'b0;
    set_lane(1, 64'hF1, 6'd8, 6'd0, 1'b0, 1'b0);
    iss_ready = 2'b11; push(0, 64'hE0); push(1, 64'hE2);
    @(negedge clk);
    n_checks++; if (iss_valid !== 2'b11) begin n_fails++; $display("FAIL ie_valid got %b required 11", iss_valid); end
    n_checks++; if (enq_ready !== 1'b1) begin n_fails++; $display("FAIL ie_enq_ready got %b required 1", enq_ready); end
    tick(); clear_lanes(); iss_ready = 2'b00;
    @(negedge clk);
    n_checks++; if (count !== 4'd3) begin n_fails++; $display("FAIL ie_count got %0d required 3", count); end
    tick(); iss_ready = 2'b11; wake_valid = 4'b1000; wake_preg = '0; wake_preg[18 +: 6] = 6'd8;
    tick(); wake_valid = '0; wake_preg = '0;
    push(0, 64'hE1); push(1, 64'hE3); push(0, 64'hF1);
    @(negedge clk);
    n_checks++; if (iss_valid !== 2'b11) begin n_fails++; $display("FAIL ie_woken_valid got %b required 11", iss_valid); end
    tick();
    @(negedge clk);
    n_checks++; if (iss_valid !== 2'b01) begin n_fails++; $display("FAIL ie_last_valid got %b required 01", iss_valid); end
    tick(); iss_ready = 2'b00;
    @(negedge clk);
    n_checks++; if (count !== 4'd0) begin n_fails++; $display("FAIL ie_drained got %0d required 0", count); end
    $display("issue+enqueue scenario done");
  endtask

  task automatic test_same_cycle_wake();
    iss_ready = 2'b01;
    tick(); clear_lanes();
    set_lane(0, 64'h70, 6'd5, 6'd9, 1'b1, 1'b0);
    set_lane(1, 64'h71, 6'd0, 6'd10, 1'b0, 1'b0);
    wake_valid = 4'b0010; wake_preg = '0; wake_preg[6 +: 6] = 6'd9;
    @(negedge clk);
    n_checks++; if (iss_valid !== 2'b00) begin n_fails++; $display("FAIL scw_empty_valid got %b required 00", iss_valid); end
    tick(); clear_lanes(); wake_valid = '0; wake_preg = '0; push(0, 64'h70);
    @(negedge clk);
    n_checks++; if (iss_valid !== 2'b01) begin n_fails++; $display("FAIL scw_valid got %b required 01", iss_valid); end
    n_checks++; if (count !== 4'd2) begin n_fails++; $display("FAIL scw_count got %0d required 2", count); end
    tick();
    @(negedge clk);
    n_checks++; if (count !== 4'd1) begin n_fails++; $display("FAIL scw_left got %0d required 1", count); end
    iss_ready = 2'b00;
    $display("same-cycle wake scenario done");
  endtask

  task automatic test_flush();
    iss_ready = 2'b11;
    tick(); clear_lanes(); set_lane(0, 64'h90, 6'd12, 6'd0, 1'b0, 1'b0); set_lane(1, 64'h91, 6'd12, 6'd0, 1'b0, 1'b0);
    tick(); clear_lanes(); set_lane(0, 64'h92, 6'd12, 6'd0, 1'b0, 1'b0); set_lane(1, 64'h93, 6'd12, 6'd0, 1'b0, 1'b0);
    tick(); clear_lanes(); set_lane(0, 64'h94, 6'd12, 6'd0, 1'b0, 1'b0);
    tick(); clear_lanes(); flush = 1'b1;
    set_lane(0, 64'h98, 6'd0, 6'd0, 1'b1, 1'b1); set_lane(1, 64'h99, 6'd0, 6'd0, 1'b1, 1'b1);
    @(negedge clk);
    n_checks++; if (count !== 4'd6) begin n_fails++; $display("FAIL flush_pre_count got %0d required 6", count); end
    n_checks++; if (iss_valid !== 2'b00) begin n_fails++; $display("FAIL flush_pre_valid got %b required 00", iss_valid); end
    tick(); flush = 1'b0; clear_lanes();
    @(negedge clk);
    n_checks++; if (count !== 4'd0) begin n_fails++; $display("FAIL flush_count got %0d required 0", count); end
    n_checks++; if (enq_ready !== 1'b1) begin n_fails++; $display("FAIL flush_enq_ready got %b required 1", enq_ready); end
    tick(); wake_valid = 4'b0011; wake_preg = '0; wake_preg[0 +: 6] = 6'd12; wake_preg[6 +: 6] = 6'd10;
    tick(); wake_valid = '0; wake_preg = '0;
    @(negedge clk);
    n_checks++; if (iss_valid !== 2'b00) begin n_fails++; $display("FAIL flush_ghost_valid got %b required 00", iss_valid); end
    n_checks++; if (count !== 4'd0) begin n_fails++; $display("FAIL flush_ghost_count got %0d required 0", count); end
    iss_ready = 2'b00;
    $display("flush scenario done");
  endtask

  task automatic test_async_reset();
    iss_ready = 2'b00;
    tick(); clear_lanes(); set_lane(0, 64'hB00, 6'd0, 6'd0, 1'b1, 1'b1); set_lane(1, 64'hB01, 6'd0, 6'd0, 1'b1, 1'b1);
    tick(); clear_lanes(); iss_ready = 2'b11;
    #1;
    n_checks++; if (iss_valid !== 2'b11) begin n_fails++; $display("FAIL arst_pre_valid got %b required 11", iss_valid); end
    rst = 1'b1;
    #1;
    n_checks++; if (iss_valid !== 2'b00) begin n_fails++; $display("FAIL arst_valid got %b required 00", iss_valid); end
    n_checks++; if (count !== 4'd0) begin n_fails++; $display("FAIL arst_count got %0d required 0", count); end
    n_checks++; if (iss_payload !== 128'd0) begin n_fails++; $display("FAIL arst_payload got %h required 0", iss_payload); end
    @(negedge clk);
    #1 rst = 1'b0; iss_ready = 2'b00;
    @(negedge clk);
    n_checks++; if (count !== 4'd0) begin n_fails++; $display("FAIL arst_after_count got %0d required 0", count); end
    $display("async reset scenario done");
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; iss_ready = '0; wake_valid = '0; wake_preg = '0;
    clear_lanes();
    test_reset();
    test_wakeup();
    test_fill();
    test_select();
    test_issue_enq();
    test_same_cycle_wake();
    test_flush();
    test_async_reset();
    n_checks++;
    if (sb.size() != 0) begin
      n_fails++;
      $display("FAIL sb_leftover got %0d outstanding issues, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
